// File: rtl/semaforo_pkg.sv
// Shared definitions for the semaforo_ctrl junction scheduler.
//   - Lamp encodings (one bit per lamp: red, yellow, green).
//   - One-hot FSM state constants. The NIGHT state only exists when
//     SEMAFORO_NIGHT_FLASH_EN is defined.
//   - Default phase durations, in ticks.
//   - max_of5: sizing helper for the phase counter.
package semaforo_pkg;

  localparam logic [2:0] LAMP_OFF    = 3'b000;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

`ifdef SEMAFORO_NIGHT_FLASH_EN
  localparam int ST_W = 7;
`else
  localparam int ST_W = 6;
`endif

  localparam logic [ST_W-1:0] ST_A_GREEN  = ST_W'(1 << 0);
  localparam logic [ST_W-1:0] ST_A_YELLOW = ST_W'(1 << 1);
  localparam logic [ST_W-1:0] ST_ALL_RED  = ST_W'(1 << 2);
  localparam logic [ST_W-1:0] ST_B_GREEN  = ST_W'(1 << 3);
  localparam logic [ST_W-1:0] ST_B_YELLOW = ST_W'(1 << 4);
  localparam logic [ST_W-1:0] ST_PED_WALK = ST_W'(1 << 5);
`ifdef SEMAFORO_NIGHT_FLASH_EN
  localparam logic [ST_W-1:0] ST_NIGHT    = ST_W'(1 << 6);
`endif

  localparam int T_MIN_GREEN_DEF = 5;
  localparam int T_YELLOW_DEF    = 1;
  localparam int T_ALLRED_DEF    = 1;
  localparam int T_B_GREEN_DEF   = 4;
  localparam int T_WALK_DEF      = 4;

  function automatic int max_of5(input int a, input int b, input int c,
                                 input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/semaforo_timer.sv
// Phase timer for semaforo_ctrl.
// Counts tick pulses. clr has priority and zeroes the count. When sat_en is
// high, the count stops at sat_val.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   tick      one-cycle count enable
//   clr       zero the count (state change)
//   sat_en    hold the count once it reaches sat_val
//   sat_val   saturation value
//   term_val  phase length T (>=1); done fires on the tick where count==T-1
//   done      terminal-count strobe (combinational)
//   at_sat    count currently equals sat_val
module semaforo_timer
  import semaforo_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         clr,
  input  logic         sat_en,
  input  logic [W-1:0] sat_val,
  input  logic [W-1:0] term_val,
  output logic         done,
  output logic         at_sat
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (tick && !(sat_en && (count_q == sat_val))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done   = tick && (count_q == (term_val - 1'b1));
  assign at_sat = (count_q == sat_val);

endmodule

// File: rtl/semaforo_ctrl.sv
// Two-approach junction scheduler with a pedestrian crossing.
// Main road A rests on green. Latched side-road (car_b) and pedestrian (bt)
// requests are served after a minimum A green. When both are pending they
// alternate round-robin. Every served phase returns to A green.
// Optional feature, macro SEMAFORO_NIGHT_FLASH_EN: a NIGHT state in which
// both approaches flash yellow while the night input is high.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   tick             one-cycle 1 Hz timing enable
//   car_b, bt        side-road sensor and pedestrian button (level or pulse)
//   night            night-mode request (only used with the macro)
//   A, B             lamps {red, yellow, green}
//   walk             pedestrian walk lamp
//   b_wait, ped_wait latched requests that are still pending
// Outputs are decoded from the registered state only.
module semaforo_ctrl
  import semaforo_pkg::*;
#(
  parameter int T_MIN_GREEN = T_MIN_GREEN_DEF,
  parameter int T_YELLOW    = T_YELLOW_DEF,
  parameter int T_ALLRED    = T_ALLRED_DEF,
  parameter int T_B_GREEN   = T_B_GREEN_DEF,
  parameter int T_WALK      = T_WALK_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       car_b,
  input  logic       bt,
  input  logic       night,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       walk,
  output logic       b_wait,
  output logic       ped_wait
);

  localparam int CW = $clog2(max_of5(T_MIN_GREEN, T_YELLOW, T_ALLRED,
                                     T_B_GREEN, T_WALK) + 1);

  localparam logic [CW-1:0] C_MIN_GREEN = CW'(T_MIN_GREEN);
  localparam logic [CW-1:0] C_YELLOW    = CW'(T_YELLOW);
  localparam logic [CW-1:0] C_ALLRED    = CW'(T_ALLRED);
  localparam logic [CW-1:0] C_B_GREEN   = CW'(T_B_GREEN);
  localparam logic [CW-1:0] C_WALK      = CW'(T_WALK);

  logic [ST_W-1:0] state_q, state_d;
  logic            b_req_q, b_req_d;
  logic            ped_req_q, ped_req_d;
  logic            last_ped_q, last_ped_d;  // 1: pedestrians served last
  logic            ret_a_q, ret_a_d;        // 1: next ALL_RED exits to A green
  logic [CW-1:0]   term;
  logic            t_done, at_min;
  logic            b_set, b_clr, p_set, p_clr;

`ifdef SEMAFORO_NIGHT_FLASH_EN
  logic night_path_q, night_path_d;  // current A_YELLOW/ALL_RED leads to NIGHT
  logic blink_q, blink_d;
`else
  logic unused_night;
  assign unused_night = night;
`endif

  // The count clears on every state change, so each phase times from zero.
  semaforo_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .clr      (state_d != state_q),
    .sat_en   (state_q == ST_A_GREEN),
    .sat_val  (C_MIN_GREEN),
    .term_val (term),
    .done     (t_done),
    .at_sat   (at_min)
  );

  always_comb begin
    term = C_YELLOW;
    case (state_q)
      ST_A_YELLOW: term = C_YELLOW;
      ST_ALL_RED:  term = C_ALLRED;
      ST_B_GREEN:  term = C_B_GREEN;
      ST_B_YELLOW: term = C_YELLOW;
      ST_PED_WALK: term = C_WALK;
      default:     term = C_YELLOW;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    last_ped_d = last_ped_q;
    ret_a_d    = ret_a_q;
`ifdef SEMAFORO_NIGHT_FLASH_EN
    night_path_d = night_path_q;
`endif
    case (state_q)
      ST_A_GREEN: begin
`ifdef SEMAFORO_NIGHT_FLASH_EN
        // Night mode pre-empts the minimum green.
        if (night) begin
          state_d      = ST_A_YELLOW;
          night_path_d = 1'b1;
        end else
`endif
        if (at_min && (b_req_q || ped_req_q)) begin
          state_d = ST_A_YELLOW;
        end
      end
      ST_A_YELLOW: begin
        if (t_done) begin
          state_d = ST_ALL_RED;
          ret_a_d = 1'b0;
        end
      end
      ST_ALL_RED: begin
        if (t_done) begin
`ifdef SEMAFORO_NIGHT_FLASH_EN
          night_path_d = 1'b0;
          if (night_path_q) begin
            state_d = ST_NIGHT;
          end else
`endif
          if (ret_a_q) begin
            state_d = ST_A_GREEN;
          end else if (b_req_q && (!ped_req_q || last_ped_q)) begin
            // Only B pending, or both pending and pedestrians had the last turn.
            state_d    = ST_B_GREEN;
            last_ped_d = 1'b0;
          end else if (ped_req_q) begin
            state_d    = ST_PED_WALK;
            last_ped_d = 1'b1;
          end else begin
            state_d = ST_A_GREEN;
          end
        end
      end
      ST_B_GREEN: begin
        if (t_done) state_d = ST_B_YELLOW;
      end
      ST_B_YELLOW: begin
        if (t_done) begin
          state_d = ST_ALL_RED;
          ret_a_d = 1'b1;
        end
      end
      ST_PED_WALK: begin
        if (t_done) begin
          state_d = ST_ALL_RED;
          ret_a_d = 1'b1;
        end
      end
`ifdef SEMAFORO_NIGHT_FLASH_EN
      ST_NIGHT: begin
        if (!night) begin
          state_d = ST_ALL_RED;
          ret_a_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_A_GREEN;
      end
    endcase
  end

  // Request latches. Clear wins over a simultaneous set.
  always_comb begin
    b_set = car_b && (state_q != ST_B_GREEN) && (state_q != ST_B_YELLOW);
    b_clr = (state_d == ST_B_GREEN) && (state_q != ST_B_GREEN);
    p_set = bt && (state_q != ST_PED_WALK);
    p_clr = (state_d == ST_PED_WALK) && (state_q != ST_PED_WALK);
`ifdef SEMAFORO_NIGHT_FLASH_EN
    if (state_q == ST_NIGHT) begin
      b_clr = 1'b1;
      p_clr = 1'b1;
    end
`endif
    b_req_d   = b_clr ? 1'b0 : (b_req_q | b_set);
    ped_req_d = p_clr ? 1'b0 : (ped_req_q | p_set);
  end

`ifdef SEMAFORO_NIGHT_FLASH_EN
  // Blink starts lit on entry to NIGHT and toggles on every tick inside it.
  always_comb begin
    blink_d = blink_q;
    if ((state_d == ST_NIGHT) && (state_q != ST_NIGHT)) begin
      blink_d = 1'b1;
    end else if ((state_q == ST_NIGHT) && tick) begin
      blink_d = ~blink_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_A_GREEN;
      b_req_q    <= 1'b0;
      ped_req_q  <= 1'b0;
      last_ped_q <= 1'b1;
      ret_a_q    <= 1'b0;
`ifdef SEMAFORO_NIGHT_FLASH_EN
      night_path_q <= 1'b0;
      blink_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      b_req_q    <= b_req_d;
      ped_req_q  <= ped_req_d;
      last_ped_q <= last_ped_d;
      ret_a_q    <= ret_a_d;
`ifdef SEMAFORO_NIGHT_FLASH_EN
      night_path_q <= night_path_d;
      blink_q      <= blink_d;
`endif
    end
  end

  // Moore output decode.
  always_comb begin
    A    = LAMP_RED;
    B    = LAMP_RED;
    walk = 1'b0;
    case (state_q)
      ST_A_GREEN:  A = LAMP_GREEN;
      ST_A_YELLOW: A = LAMP_YELLOW;
      ST_B_GREEN:  B = LAMP_GREEN;
      ST_B_YELLOW: B = LAMP_YELLOW;
      ST_PED_WALK: walk = 1'b1;
`ifdef SEMAFORO_NIGHT_FLASH_EN
      ST_NIGHT: begin
        A = blink_q ? LAMP_YELLOW : LAMP_OFF;
        B = blink_q ? LAMP_YELLOW : LAMP_OFF;
      end
`endif
      default: ;
    endcase
  end

  assign b_wait   = b_req_q;
  assign ped_wait = ped_req_q;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Directed testbench for semaforo_ctrl with default timing.
// Each "period" is four clocks with tick high in the first one. Outputs are
// sampled at the falling edge that ends the period, after the state has settled.
module tb_semaforo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       car_b = 1'b0;
  logic       bt = 1'b0;
  logic       night = 1'b0;
  logic [2:0] A, B;
  logic       walk, b_wait, ped_wait;

  int tests = 0;
  int fails = 0;

  // Lamp patterns {A, B, walk}
  localparam logic [6:0] L_AG = 7'b001_100_0;
  localparam logic [6:0] L_AY = 7'b010_100_0;
  localparam logic [6:0] L_AR = 7'b100_100_0;
  localparam logic [6:0] L_BG = 7'b100_001_0;
  localparam logic [6:0] L_BY = 7'b100_010_0;
  localparam logic [6:0] L_PW = 7'b100_100_1;

  logic [8:0] obs;
  assign obs = {A, B, walk, b_wait, ped_wait};

  always #5 clk = ~clk;

  semaforo_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .car_b    (car_b),
    .bt       (bt),
    .night    (night),
    .A        (A),
    .B        (B),
    .walk     (walk),
    .b_wait   (b_wait),
    .ped_wait (ped_wait)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic period(input logic tk, input logic cb, input logic b);
    @(negedge clk);
    tick = tk; car_b = cb; bt = b;
    @(negedge clk);
    tick = 1'b0; car_b = 1'b0; bt = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick = 1'b0; car_b = 1'b0; bt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    do_reset();
    exp = {L_AG, 1'b0, 1'b0};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL reset_state: got %b required %b", obs, exp);
    end
    for (int k = 1; k <= 20; k++) begin
      period(1'b1, 1'b0, 1'b0);
      tests++;
      $display("[TB] idle tick %0d obs=%b", k, obs);
      if (obs !== exp) begin
        fails++;
        $display("FAIL idle_green tick %0d: got %b required %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_car();
    logic [8:0] exp;
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      period(1'b1, k == 2, 1'b0);
      case (k)
        1:             exp = {L_AG, 1'b0, 1'b0};
        2, 3, 4:       exp = {L_AG, 1'b1, 1'b0};
        5:             exp = {L_AY, 1'b1, 1'b0};
        6:             exp = {L_AR, 1'b1, 1'b0};
        7, 8, 9, 10:   exp = {L_BG, 1'b0, 1'b0};
        11:            exp = {L_BY, 1'b0, 1'b0};
        12:            exp = {L_AR, 1'b0, 1'b0};
        default:       exp = {L_AG, 1'b0, 1'b0};
      endcase
      tests++;
      $display("[TB] car tick %0d obs=%b", k, obs);
      if (obs !== exp) begin
        fails++;
        $display("FAIL car_seq tick %0d: got %b required %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_ped();
    logic [8:0] exp;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      period(1'b1, 1'b0, k == 7);
      case (k)
        7:              exp = {L_AY, 1'b0, 1'b1};
        8:              exp = {L_AR, 1'b0, 1'b1};
        9, 10, 11, 12:  exp = {L_PW, 1'b0, 1'b0};
        13:             exp = {L_AR, 1'b0, 1'b0};
        default:        exp = {L_AG, 1'b0, 1'b0};
      endcase
      tests++;
      $display("[TB] ped tick %0d obs=%b", k, obs);
      if (obs !== exp) begin
        fails++;
        $display("FAIL ped_seq tick %0d: got %b required %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] exp;
    logic       chk;
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      period(1'b1, (k == 1) || (k == 8) || (k == 26) || (k == 40),
             (k == 1) || (k == 8) || (k == 26));
      chk = 1'b1;
      exp = '0;
      case (k)
        1:       exp = {L_AG, 1'b1, 1'b1};
        6:       exp = {L_AR, 1'b1, 1'b1};
        7:       exp = {L_BG, 1'b0, 1'b1};  // B first after reset
        8:       exp = {L_BG, 1'b0, 1'b1};  // car_b ignored in B_GREEN
        13:      exp = {L_AG, 1'b0, 1'b1};
        17:      exp = {L_AG, 1'b0, 1'b1};  // min green not yet done
        18:      exp = {L_AY, 1'b0, 1'b1};
        20:      exp = {L_PW, 1'b0, 1'b0};
        25:      exp = {L_AG, 1'b0, 1'b0};
        26:      exp = {L_AG, 1'b1, 1'b1};
        32:      exp = {L_BG, 1'b0, 1'b1};  // last was ped -> B
        40:      exp = {L_AG, 1'b1, 1'b1};
        44:      exp = {L_AR, 1'b1, 1'b1};
        45:      exp = {L_PW, 1'b1, 1'b0};  // last was B -> ped
        default: chk = 1'b0;
      endcase
      if (chk) begin
        tests++;
        $display("[TB] rr tick %0d obs=%b", k, obs);
        if (obs !== exp) begin
          fails++;
          $display("FAIL round_robin tick %0d: got %b required %b", k, obs, exp);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [8:0] exp;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      period(1'b1, k == 1, k == 8);
    end
    exp = {L_BG, 1'b0, 1'b1};
    tests++;
    $display("[TB] midrst before obs=%b", obs);
    if (obs !== exp) begin
      fails++;
      $display("FAIL midrst_pre: got %b required %b", obs, exp);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp = {L_AG, 1'b0, 1'b0};
    tests++;
    $display("[TB] midrst after obs=%b", obs);
    if (obs !== exp) begin
      fails++;
      $display("FAIL midrst_post: got %b required %b", obs, exp);
    end
    // Counter must restart from zero: yellow only after the 5th tick.
    for (int k = 1; k <= 5; k++) begin
      period(1'b1, k == 1, 1'b0);
      if (k >= 4) begin
        exp = (k == 4) ? {L_AG, 1'b1, 1'b0} : {L_AY, 1'b1, 1'b0};
        tests++;
        $display("[TB] midrst tick %0d obs=%b", k, obs);
        if (obs !== exp) begin
          fails++;
          $display("FAIL midrst_count tick %0d: got %b required %b", k, obs, exp);
        end
      end
    end
  endtask

  task automatic test_night();
    logic [8:0] exp [7];
    do_reset();
    night = 1'b1;
`ifdef SEMAFORO_NIGHT_FLASH_EN
    exp[0] = {L_AY, 1'b0, 1'b0};
    exp[1] = {L_AR, 1'b0, 1'b0};
    exp[2] = {3'b010, 3'b010, 1'b0, 1'b0, 1'b0};
    exp[3] = {3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
    exp[4] = {3'b010, 3'b010, 1'b0, 1'b0, 1'b0};
    exp[5] = {L_AR, 1'b0, 1'b0};
    exp[6] = {L_AG, 1'b0, 1'b0};
    for (int k = 0; k < 7; k++) begin
      if (k == 5) night = 1'b0;
      period((k != 0) && (k != 5), k == 4, k == 3);
      tests++;
      $display("[TB] night step %0d obs=%b", k, obs);
      if (obs !== exp[k]) begin
        fails++;
        $display("FAIL night step %0d: got %b required %b", k, obs, exp[k]);
      end
    end
`else
    // Without the feature, night has no effect.
    for (int k = 0; k < 7; k++) exp[k] = {L_AG, 1'b0, 1'b0};
    for (int k = 0; k < 7; k++) begin
      period(1'b1, 1'b0, 1'b0);
      tests++;
      $display("[TB] night-ignored step %0d obs=%b", k, obs);
      if (obs !== exp[k]) begin
        fails++;
        $display("FAIL night_ignored step %0d: got %b required %b", k, obs, exp[k]);
      end
    end
`endif
    night = 1'b0;
  endtask

  initial begin
    test_reset();
    test_car();
    test_ped();
    test_round_robin();
    test_mid_reset();
    test_night();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
